// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - opcodes, field layout, decode record and FSM encoding for the fetch/decode front end
package isa_pkg;

  localparam int IW_DEF = 18;
  localparam int PW_DEF = 6;
  localparam int OP_W   = 6;

  localparam int OP_LSB = 2 * PW_DEF;
  localparam int P1_LSB = PW_DEF;
  localparam int P2_LSB = 0;

  localparam logic [OP_W-1:0] OP_NOP  = 6'b000000;
  localparam logic [OP_W-1:0] OP_ALU  = 6'b000001;
  localparam logic [OP_W-1:0] OP_MOV  = 6'b000010;
  localparam logic [OP_W-1:0] OP_LDI  = 6'b000011;
  localparam logic [OP_W-1:0] OP_JMP  = 6'b000100;
  localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_DECODE = 3'd3;
  localparam logic [2:0] ST_EXEC   = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  // start_sel is one-hot {ldi, mov, alu}
  typedef struct packed {
    logic       is_exec;
    logic [2:0] start_sel;
    logic       is_jmp;
    logic       is_halt;
    logic       is_illegal;
  } dec_t;

endpackage

// File: rtl/instr_fetch_decode_if.sv
// rtl/instr_fetch_decode_if.sv - program memory read bus between fetch unit and instruction memory
interface instr_fetch_decode_if #(
  parameter int AW = 8,
  parameter int IW = isa_pkg::IW_DEF
);
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [IW-1:0] mem_data;

  modport master (output mem_addr, output mem_rd, input mem_data);
  modport slave  (input mem_addr, input mem_rd, output mem_data);
endinterface

// File: rtl/opcode_decode.sv
// rtl/opcode_decode.sv - combinational opcode classifier
module opcode_decode
  import isa_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output dec_t            dec
);

  always_comb begin
    dec = '0;
    case (opcode)
      OP_NOP:  ;
      OP_ALU:  begin dec.is_exec = 1'b1; dec.start_sel = 3'b001; end
      OP_MOV:  begin dec.is_exec = 1'b1; dec.start_sel = 3'b010; end
      OP_LDI:  begin dec.is_exec = 1'b1; dec.start_sel = 3'b100; end
      OP_JMP:  dec.is_jmp = 1'b1;
      OP_HALT: dec.is_halt = 1'b1;
      default: dec.is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// rtl/instr_fetch_decode.sv - instruction sequencer: fetch, decode, dispatch to execution FSMs, watchdog
module instr_fetch_decode
  import isa_pkg::*;
#(
  parameter int            AW       = 8,
  parameter int            IW       = IW_DEF,
  parameter int            PW       = PW_DEF,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  instr_fetch_decode_if.master  mem,
  input  logic                  exec_done,
  output logic [PW-1:0]         parameter1,
  output logic [PW-1:0]         parameter2,
  output logic                  donefetch,
  output logic                  start_alu,
  output logic                  start_mov,
  output logic                  start_ldi,
  output logic [AW-1:0]         pc,
  output logic                  halted,
  output logic                  illegal,
  output logic                  timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [2:0]    state;
  logic [IW-1:0] ir;
  logic [CW-1:0] wd_cnt;
  dec_t          dec;

  opcode_decode u_dec (
    .opcode (ir[IW-1 -: OP_W]),
    .dec    (dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      ir         <= '0;
      parameter1 <= '0;
      parameter2 <= '0;
      illegal    <= 1'b0;
      timeout    <= 1'b0;
      wd_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (run) state <= ST_FETCH;
        ST_FETCH: state <= ST_WAIT;
        ST_WAIT: begin
          ir    <= mem.mem_data;
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          parameter1 <= ir[P1_LSB +: PW];
          parameter2 <= ir[P2_LSB +: PW];
          wd_cnt     <= '0;
          if (dec.is_jmp) pc <= AW'(ir[2*PW-1:0]);
          else            pc <= pc + AW'(1);
          if (dec.is_illegal) begin
            illegal <= 1'b1;
            state   <= ST_HALT;
          end else if (dec.is_halt) begin
            state <= ST_HALT;
          end else if (dec.is_exec) begin
            state <= ST_EXEC;
          end else begin
            state <= run ? ST_FETCH : ST_IDLE;
          end
        end
        ST_EXEC: begin
          // exec_done takes priority over a watchdog trip in the same cycle
          if (exec_done) begin
            state <= run ? ST_FETCH : ST_IDLE;
          end else if (wd_cnt == CW'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
            state   <= ST_HALT;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        ST_HALT:  ;
        default:  state <= ST_HALT;
      endcase
    end
  end

  assign mem.mem_addr = pc;
  assign mem.mem_rd   = (state == ST_FETCH);
  assign donefetch    = (state == ST_DECODE);
  assign halted       = (state == ST_HALT);
  assign start_alu    = (state == ST_EXEC) && dec.start_sel[0];
  assign start_mov    = (state == ST_EXEC) && dec.start_sel[1];
  assign start_ldi    = (state == ST_EXEC) && dec.start_sel[2];

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb/tb_instr_fetch_decode.sv - self-checking bench for instr_fetch_decode
module tb_instr_fetch_decode;

  typedef struct {
    logic [17:0] instr;
    int          n;
    logic [5:0]  p1;
    logic [5:0]  p2;
    logic [2:0]  start;
    logic [7:0]  pc;
    logic        halted;
    logic        illegal;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic       exec_done = 1'b0;
  logic [5:0] parameter1, parameter2;
  logic       donefetch, start_alu, start_mov, start_ldi;
  logic       halted, illegal, timeout;
  logic [7:0] pc;

  logic [17:0] mem [256];
  int          checks = 0;
  int          errors = 0;
  vec_t        sb [$];
  vec_t        vecs [8];
  bit          mon_en = 1'b0;
  bit          prev_df = 1'b0;

  instr_fetch_decode_if #(.AW(8), .IW(18)) mem_if ();

  instr_fetch_decode #(
    .AW(8), .IW(18), .PW(6), .RESET_PC(8'h00), .TIMEOUT(64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .mem        (mem_if),
    .exec_done  (exec_done),
    .parameter1 (parameter1),
    .parameter2 (parameter2),
    .donefetch  (donefetch),
    .start_alu  (start_alu),
    .start_mov  (start_mov),
    .start_ldi  (start_ldi),
    .pc         (pc),
    .halted     (halted),
    .illegal    (illegal),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_if.mem_rd) mem_if.mem_data <= mem[mem_if.mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: the cycle after each DECODE, compare against the queued expectation
  always @(negedge clk) begin
    vec_t e;
    if (!mon_en) begin
      prev_df = 1'b0;
    end else begin
      if (prev_df) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_decode: got donefetch with empty scoreboard");
        end else begin
          e = sb.pop_front();
          chk("vec_p1", 32'(parameter1), 32'(e.p1));
          chk("vec_p2", 32'(parameter2), 32'(e.p2));
          chk("vec_start", 32'({start_ldi, start_mov, start_alu}), 32'(e.start));
          chk("vec_pc", 32'(pc), 32'(e.pc));
          chk("vec_halted", 32'(halted), 32'(e.halted));
          chk("vec_illegal", 32'(illegal), 32'(e.illegal));
        end
      end
      prev_df = donefetch;
    end
  end

  task automatic do_reset();
    run = 1'b0;
    exec_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int n_start;
    do_reset();
    mem[0] = v.instr;
    mem[1] = 18'h00000;
    sb.push_back(v);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    n_start = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (start_alu | start_mov | start_ldi) begin
        n_start++;
        exec_done = (n_start == v.n);
      end else begin
        exec_done = 1'b0;
      end
    end
    exec_done = 1'b0;
    chk("vec_exec_cycles", 32'(n_start), 32'(v.n));
  endtask

  initial begin
    int rise_t, halt_t, n_hi, n_rd, n_df, n_st;
    int rd_t [4];
    logic [7:0] rd_a [4];
    bit seen;

    for (int i = 0; i < 256; i++) mem[i] = 18'h00000;

    vecs[0] = '{18'h01042, 7, 6'd1,  6'd2,  3'b001, 8'h01, 1'b0, 1'b0};
    vecs[1] = '{18'h020C5, 1, 6'd3,  6'd5,  3'b010, 8'h01, 1'b0, 1'b0};
    vecs[2] = '{18'h03FC0, 3, 6'd63, 6'd0,  3'b100, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{18'h00000, 0, 6'd0,  6'd0,  3'b000, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{18'h040A5, 0, 6'd2,  6'd37, 3'b000, 8'hA5, 1'b0, 1'b0};
    vecs[5] = '{18'h3F041, 0, 6'd1,  6'd1,  3'b000, 8'h01, 1'b1, 1'b0};
    vecs[6] = '{18'h2A000, 0, 6'd0,  6'd0,  3'b000, 8'h01, 1'b1, 1'b1};
    vecs[7] = '{18'h04FFF, 0, 6'd63, 6'd63, 3'b000, 8'hFF, 1'b0, 1'b0};

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_ctrl", 32'({mem_if.mem_rd, donefetch, start_alu, start_mov, start_ldi, halted, illegal, timeout}), 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_addr", 32'(mem_if.mem_addr), 32'h0);
    chk("rst_params", 32'({parameter1, parameter2}), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    mon_en = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'h0);

    // ALU r1,r2 leaves the next fetch address at 1
    run_vec(vecs[0]);
    chk("alu_next_addr", 32'(mem_if.mem_addr), 32'h1);
    sb.delete();

    // JMP 0xFF, NOP at 0xFF wraps pc to 0; fetch strobes 3 cycles apart
    do_reset();
    mem[0] = 18'h040FF;
    mem[255] = 18'h00000;
    run = 1'b1;
    n_rd = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_if.mem_rd && n_rd < 4) begin
        rd_t[n_rd] = c;
        rd_a[n_rd] = mem_if.mem_addr;
        n_rd++;
      end
    end
    run = 1'b0;
    chk("jmp_n_fetch", 32'(n_rd >= 3), 32'h1);
    chk("jmp_addr0", 32'(rd_a[0]), 32'h00);
    chk("jmp_addr1", 32'(rd_a[1]), 32'hFF);
    chk("jmp_addr_wrap", 32'(rd_a[2]), 32'h00);
    chk("jmp_gap1", 32'(rd_t[1] - rd_t[0]), 32'd3);
    chk("jmp_gap2", 32'(rd_t[2] - rd_t[1]), 32'd3);

    // Illegal opcode halts with no further fetches or starts
    do_reset();
    mem[0] = 18'h2A000;
    run = 1'b1;
    for (int c = 0; c < 6; c++) @(negedge clk);
    n_rd = 0;
    n_st = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_if.mem_rd) n_rd++;
      if (start_alu | start_mov | start_ldi) n_st++;
    end
    chk("ill_flag", 32'(illegal), 32'h1);
    chk("ill_halted", 32'(halted), 32'h1);
    chk("ill_no_rd", 32'(n_rd), 32'h0);
    chk("ill_no_start", 32'(n_st), 32'h0);
    run = 1'b0;

    // Watchdog: ALU without exec_done
    do_reset();
    mem[0] = 18'h01042;
    run = 1'b1;
    rise_t = -1;
    halt_t = -1;
    n_hi = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (start_alu) n_hi++;
      if (start_alu && rise_t < 0) rise_t = c;
      if (halted && halt_t < 0) halt_t = c;
    end
    chk("wd_latency", 32'(halt_t - rise_t), 32'd64);
    chk("wd_start_cycles", 32'(n_hi), 32'd64);
    chk("wd_timeout", 32'(timeout), 32'h1);
    chk("wd_start_low", 32'(start_alu), 32'h0);
    chk("wd_not_illegal", 32'(illegal), 32'h0);

    // run dropped during MOV execution: completes, then idles
    do_reset();
    mem[0] = 18'h020C5;
    mem[1] = 18'h00000;
    run = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (start_mov) seen = 1'b1;
    end
    chk("mov_started", 32'(seen), 32'h1);
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mov_still_exec", 32'(start_mov), 32'h1);
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    n_rd = 0;
    n_df = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_if.mem_rd) n_rd++;
      if (donefetch) n_df++;
    end
    chk("mov_no_rd", 32'(n_rd), 32'h0);
    chk("mov_no_decode", 32'(n_df), 32'h0);
    chk("mov_start_low", 32'(start_mov), 32'h0);
    chk("mov_not_halted", 32'(halted), 32'h0);
    chk("mov_pc", 32'(pc), 32'h1);

    // Asynchronous reset during EXEC, then restart from RESET_PC
    do_reset();
    mem[0] = 18'h01042;
    run = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (start_alu) seen = 1'b1;
    end
    chk("arst_in_exec", 32'(seen), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ctrl", 32'({mem_if.mem_rd, donefetch, start_alu, start_mov, start_ldi, halted, illegal, timeout}), 32'h0);
    chk("arst_pc", 32'(pc), 32'h0);
    chk("arst_params", 32'({parameter1, parameter2}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clk);
      if (mem_if.mem_rd) begin
        seen = 1'b1;
        chk("arst_refetch_addr", 32'(mem_if.mem_addr), 32'h0);
      end
    end
    chk("arst_refetch", 32'(seen), 32'h1);
    run = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Front-end sequencer of the microcontroller; sits directly upstream of the ALU-operation, move and load-immediate execution FSMs.
- Fetches instruction words from program memory, decodes opcode and two 6-bit register/operand fields, and drives `parameter1`/`parameter2`.
- Pulses `donefetch` to return execution FSMs to their initial state, then holds the selected `start_*` level until that FSM reports `exec_done`.
- Handles NOP, JMP and HALT internally, plus an execution watchdog.

Parameters:
- AW, 8, program-counter and memory-address width
- IW, 18, instruction word width; layout is {opcode[17:12], param1[11:6], param2[5:0]}
- PW, 6, width of each parameter field
- RESET_PC, 0, PC value loaded at reset
- TIMEOUT, 64, maximum EXEC cycles before the watchdog trips

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset
- run  in  1  level; enables instruction sequencing
- mem_addr  out  AW  program memory address
- mem_rd  out  1  read strobe; data valid on `mem_data` exactly one cycle later
- mem_data  in  IW  instruction word from memory
- exec_done  in  1  OR of the execution FSMs' `done` outputs
- parameter1  out  PW  destination/first register field
- parameter2  out  PW  source/second register field
- donefetch  out  1  one-cycle pulse; resets execution FSMs
- start_alu  out  1  level start for the ALU-operation FSM
- start_mov  out  1  level start for the move FSM
- start_ldi  out  1  level start for the load-immediate FSM
- pc  out  AW  current program counter
- halted  out  1  core stopped
- illegal  out  1  sticky; undefined opcode fetched
- timeout  out  1  sticky; watchdog expired

Behaviour:
- Clocking and reset:
  - Single clock, `clk`.
  - `rst` is asynchronous and active-high.
  - On reset: pc=RESET_PC, state=IDLE, all outputs 0 (parameters 0, mem_addr=RESET_PC).
  - Reset mid-operation aborts immediately; no memory write side-effects exist.
- States: IDLE, FETCH, WAIT, DECODE, EXEC, HALT. All outputs are registered or Moore-decoded from the state.
- IDLE: go to FETCH when run=1; otherwise stay.
- FETCH: mem_rd=1, mem_addr=pc; go to WAIT.
- WAIT: capture mem_data into the IR at the end of the cycle; go to DECODE.
- DECODE:
  - parameter1/parameter2 are loaded from the IR and held stable until the next DECODE.
  - donefetch=1 for this cycle only.
  - pc <= pc+1, wrapping from 2^AW-1 to 0, except on JMP.
  - Opcodes:
    - 000000 NOP: go to FETCH, or to IDLE if run=0.
    - 000001 ALU: go to EXEC.
    - 000010 MOV: go to EXEC.
    - 000011 LDI: go to EXEC.
    - 000100 JMP: pc <= {param1,param2}[AW-1:0]; go to FETCH/IDLE as for NOP.
    - 111111 HALT: go to HALT.
    - Any other opcode: illegal<=1; go to HALT.
- EXEC:
  - Exactly one of start_alu/start_mov/start_ldi is high, chosen by the latched opcode.
  - The watchdog counter clears on EXEC entry and increments each cycle.
  - exec_done=1 (accepted in any EXEC cycle, including the first): drop start; go to FETCH if run=1, else IDLE.
  - Counter reaches TIMEOUT-1 with no exec_done: timeout<=1; go to HALT.
  - exec_done and timeout in the same cycle: exec_done wins.
- HALT:
  - halted=1; all start_* outputs and mem_rd are 0.
  - Left only by reset.
- run handling:
  - run is sampled only at instruction boundaries: IDLE, and the FETCH/IDLE decision after DECODE or EXEC.
  - Deasserting run never aborts an instruction in progress.
- exec_done outside EXEC is ignored.
- Latency:
  - NOP/JMP: 3 cycles per instruction.
  - ALU/MOV/LDI: 3 + n cycles, where n ≥ 1 is the number of EXEC cycles.
- donefetch occurs exactly once per fetched instruction, always in the DECODE cycle.

Decomposition:
- Shared package `isa_pkg` holds:
  - opcode constants (OP_NOP, OP_ALU, OP_MOV, OP_LDI, OP_JMP, OP_HALT)
  - field positions, and IW/PW defaults
  - state encoding for this FSM
- One natural sub-module: `opcode_decode`, combinational. It maps opcode to {is_exec, start_sel[2:0], is_jmp, is_halt, is_illegal}.

Test Plan:
- Reset, then run=1 with mem[0]=ALU r1,r2 (18'h01042) and exec_done asserted 7 cycles after start_alu rises:
  - parameter1=1, parameter2=2
  - donefetch pulses once, then start_alu is high for 7 cycles
  - next mem_addr=1
- mem[0]=JMP 0x0FF, then mem[0xFF]=NOP:
  - pc goes 0 → 0xFF
  - after the NOP, pc wraps to 0x00
  - 3 cycles between FETCH strobes
- mem[0]=opcode 6'b101010 → illegal=1, halted=1, no start_* asserted, and mem_rd stays 0 for 20 cycles.
- ALU instruction with exec_done never asserted → timeout=1 and halted=1 exactly TIMEOUT cycles after start_alu rises; start_alu then falls.
- run dropped during EXEC of MOV → instruction completes on exec_done and the block returns to IDLE with no further mem_rd.
- rst pulsed in EXEC → all outputs 0 asynchronously and pc=RESET_PC; with run=1 held, the fetch restarts at RESET_PC.
